// File: rtl/scoreboard_pkg.sv
// +--------------------------------------------------------------------------+
// | scoreboard_pkg : shared state encoding and active-low 7-seg constants    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package scoreboard_pkg;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      WON        = 2'd1,
      MATCH_OVER = 2'd2
   } state_t;

   // Segment order gfedcba, active-low
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/hex_digit.sv
// +--------------------------------------------------------------------------+
// | hex_digit : 4-bit value to active-low 7-segment digit, blank above 9     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hex_digit
   import scoreboard_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (value)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/win_scoreboard.sv
// +--------------------------------------------------------------------------+
// | win_scoreboard : latches round winner, blinks it, keeps per-player score |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module win_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int SCORE_MAX = 9,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [N_PLAYERS-1:0]             win,
   input  logic                             new_round,
   output logic [$clog2(N_PLAYERS+1)-1:0]   winner,
   output logic                             round_over,
   output logic                             match_over,
   output logic [6:0]                       winner_leds,
   output logic [7*N_PLAYERS-1:0]           score_leds
);

   localparam int c_win_w   = $clog2(N_PLAYERS+1);
   localparam int c_blink_w = $clog2(BLINK_DIV+1);
   localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV-1);
   localparam logic [3:0]           c_score_max  = 4'(SCORE_MAX);

   state_t               r_state;
   state_t               w_next_state;
   logic [c_win_w-1:0]   r_winner;
   logic [c_win_w-1:0]   w_first;
   logic [3:0]           w_first_score;
   logic [3:0]           r_score [N_PLAYERS];
   logic                 w_take_win;
   logic                 w_enter_won;
   logic [c_blink_w-1:0] r_blink_cnt;
   logic                 r_blank;
   logic [3:0]           w_winner_val;
   logic [6:0]           w_winner_seg;

   // Lowest-index set bit wins; scanning downward leaves the lowest one last
   always_comb begin
      w_first       = '0;
      w_first_score = '0;
      for (int i = N_PLAYERS-1; i >= 0; i--) begin
         if (win[i]) begin
            w_first       = c_win_w'(i+1);
            w_first_score = r_score[i];
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_take_win   = 1'b0;
      case (r_state)
         PLAY: begin
            if (|win) begin
               w_take_win   = 1'b1;
               w_next_state = ((w_first_score + 4'd1) == c_score_max) ? MATCH_OVER : WON;
            end
         end
         WON: begin
            if (new_round) w_next_state = PLAY;
         end
         MATCH_OVER: w_next_state = MATCH_OVER;
         default:    w_next_state = PLAY;
      endcase
      w_enter_won = w_take_win && (w_next_state == WON);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= PLAY;
         r_winner    <= '0;
         r_blink_cnt <= '0;
         r_blank     <= 1'b0;
         for (int i = 0; i < N_PLAYERS; i++) r_score[i] <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_take_win)
            r_winner <= w_first;
         else if (r_state == WON && new_round)
            r_winner <= '0;

         for (int i = 0; i < N_PLAYERS; i++) begin
            if (w_take_win && w_first == c_win_w'(i+1) && r_score[i] != c_score_max)
               r_score[i] <= r_score[i] + 4'd1;
         end

         // Restart on entry so the digit is always visible for a full half-period first
         if (w_enter_won) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
         end else if (r_state == WON) begin
            if (r_blink_cnt == c_blink_last) begin
               r_blink_cnt <= '0;
               r_blank     <= ~r_blank;
            end else begin
               r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
            end
         end
      end
   end

   assign winner       = r_winner;
   assign round_over   = (r_state != PLAY);
   assign match_over   = (r_state == MATCH_OVER);
   assign w_winner_val = 4'(r_winner);
   assign winner_leds  = (r_state == WON && r_blank) ? SEG_BLANK : w_winner_seg;

   hex_digit u_winner_digit (
      .value (w_winner_val),
      .seg   (w_winner_seg)
   );

   for (genvar i = 0; i < N_PLAYERS; i++) begin : g_score
      hex_digit u_score_digit (
         .value (r_score[i]),
         .seg   (score_leds[7*i +: 7])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_win_scoreboard.sv
// +--------------------------------------------------------------------------+
// | tb_win_scoreboard : directed + random stimulus against a round model     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_win_scoreboard;

   localparam int NP = 3;
   localparam int SM = 3;
   localparam int BD = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [NP-1:0]   win = '0;
   logic            new_round = 1'b0;
   logic [1:0]      winner;
   logic            round_over;
   logic            match_over;
   logic [6:0]      winner_leds;
   logic [7*NP-1:0] score_leds;

   always #5 clock = ~clock;

   win_scoreboard #(
      .N_PLAYERS (NP),
      .SCORE_MAX (SM),
      .BLINK_DIV (BD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .win         (win),
      .new_round   (new_round),
      .winner      (winner),
      .round_over  (round_over),
      .match_over  (match_over),
      .winner_leds (winner_leds),
      .score_leds  (score_leds)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
   logic [6:0] seg_blank = 7'b1111111;

   // Round-level model: 0 = no winner, 1 = round won, 2 = match decided
   int m_phase;
   int m_winner;
   int m_score [NP];
   int m_age;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [NP-1:0] w, input logic nr, input logic rst);
      int p;
      p = 0;
      if (rst) begin
         m_phase  = 0;
         m_winner = 0;
         m_age    = 0;
         for (int i = 0; i < NP; i++) m_score[i] = 0;
      end else if (m_phase == 0) begin
         if (w != 0) begin
            for (int i = NP-1; i >= 0; i--) if (w[i]) p = i + 1;
            m_winner = p;
            m_score[p-1]++;
            m_age    = 0;
            m_phase  = (m_score[p-1] == SM) ? 2 : 1;
         end
      end else if (m_phase == 1) begin
         if (nr) begin
            m_phase  = 0;
            m_winner = 0;
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic check_all();
      logic [6:0]      exp_leds;
      logic [7*NP-1:0] exp_sc;
      if (m_phase == 0)
         exp_leds = seg_tbl[0];
      else if (m_phase == 1)
         exp_leds = (((m_age / BD) % 2) == 0) ? seg_tbl[m_winner] : seg_blank;
      else
         exp_leds = seg_tbl[m_winner];
      for (int i = 0; i < NP; i++) exp_sc[7*i +: 7] = seg_tbl[m_score[i]];
      check("winner",      32'(winner),      32'(m_winner));
      check("round_over",  32'(round_over),  32'(m_phase != 0));
      check("match_over",  32'(match_over),  32'(m_phase == 2));
      check("winner_leds", 32'(winner_leds), 32'(exp_leds));
      check("score_leds",  32'(score_leds),  32'(exp_sc));
   endtask

   task automatic step(input logic [NP-1:0] w, input logic nr, input logic rst);
      win       = w;
      new_round = nr;
      reset     = rst;
      @(posedge clock);
      model_edge(w, nr, rst);
      #1;
      check_all();
   endtask

   initial begin
      logic [NP-1:0] rw;
      logic          rnr;
      logic          rrst;

      // Reset, first win, one full blink period
      step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);
      step(3'b001, 1'b0, 1'b0);
      repeat (8) step('0, 1'b0, 1'b0);

      // Reset while the digit is blank
      repeat (4) step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b1);

      // Simultaneous win, then a late win ignored in WON
      step(3'b110, 1'b0, 1'b0);
      step(3'b001, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);

      // new_round and win collide in WON
      step(3'b001, 1'b0, 1'b0);
      step(3'b001, 1'b1, 1'b0);
      step(3'b001, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);

      // Player 2 reaches the match score
      step(3'b010, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);
      step(3'b010, 1'b0, 1'b0);
      repeat (20) step('0, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);
      step(3'b001, 1'b0, 1'b0);
      step('0, 1'b0, 1'b1);

      // Alternating rounds
      for (int r = 0; r < 3; r++) begin
         step((r % 2 == 0) ? 3'b001 : 3'b010, 1'b0, 1'b0);
         step('0, 1'b0, 1'b0);
         step('0, 1'b1, 1'b0);
      end
      step('0, 1'b0, 1'b1);

      // Random traffic
      for (int k = 0; k < 500; k++) begin
         rw   = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
         rnr  = ($urandom_range(0, 3) == 0);
         rrst = ($urandom_range(0, 60) == 0);
         step(rw, rnr, rrst);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
